// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: digit enables, blank codes and
// banner glyphs, all active-low.
package seg_scan_ctrl_pkg;

  localparam logic [3:0] SEG_EN_D0 = 4'b0111;
  localparam logic [3:0] SEG_EN_D1 = 4'b1011;
  localparam logic [3:0] SEG_EN_D2 = 4'b1101;
  localparam logic [3:0] SEG_EN_D3 = 4'b1110;
  localparam logic [3:0] EN_OFF    = 4'hF;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] SEG_S   = 8'h92;
  localparam logic [7:0] SEG_U   = 8'hC1;
  localparam logic [7:0] SEG_C   = 8'hC6;

  typedef enum logic {PhBlank, PhDrive} phase_e;

  function automatic logic [3:0] digit_en(input logic [1:0] dig);
    logic [3:0] en;
    unique case (dig)
      2'd0:    en = SEG_EN_D0;
      2'd1:    en = SEG_EN_D1;
      2'd2:    en = SEG_EN_D2;
      default: en = SEG_EN_D3;
    endcase
    return en;
  endfunction

  // "SUCC" banner, leftmost digit first.
  function automatic logic [7:0] banner_code(input logic [1:0] dig);
    logic [7:0] seg;
    unique case (dig)
      2'd0:    seg = SEG_S;
      2'd1:    seg = SEG_U;
      default: seg = SEG_C;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit to active-low seven-segment hex decoder, {dp,g,f,e,d,c,b,a}; dp off.
module seg_hex_decode (
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'hFF;
    unique case (nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode scan controller: slot/digit counters, per-frame input snapshot,
// blank/drive phase and banner/hex/dark priority mux feeding registered outputs.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned DIV   = 65536,
  parameter int unsigned BLANK = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pass,
  input  logic        err,
  input  logic [15:0] value,
  output logic [3:0]  segan_en,
  output logic [7:0]  segans,
  output logic        frame_tick
);

  localparam int unsigned   CntW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);
  localparam int            BlankInt = int'(BLANK);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      dig_q, dig_d;
  logic            s_pass_q, s_err_q;
  logic [15:0]     s_value_q;
  logic [3:0]      en_q, en_d;
  logic [7:0]      seg_q, seg_d;
  logic            tick_q, tick_d;
  logic            slot_end, frame_end;
  phase_e          phase;
  logic [3:0]      nibble;
  logic [7:0]      hex_seg;

  seg_hex_decode u_hex (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  always_comb begin
    slot_end  = (cnt_q == CntLast);
    frame_end = slot_end && (dig_q == 2'd3);
    cnt_d     = slot_end ? '0 : cnt_q + CntW'(1);
    dig_d     = slot_end ? dig_q + 2'd1 : dig_q;
    // Signed compare keeps BLANK == 0 from becoming a constant unsigned test.
    phase     = (int'({1'b0, cnt_q}) < BlankInt) ? PhBlank : PhDrive;

    unique case (dig_q)
      2'd0:    nibble = s_value_q[15:12];
      2'd1:    nibble = s_value_q[11:8];
      2'd2:    nibble = s_value_q[7:4];
      default: nibble = s_value_q[3:0];
    endcase

    en_d   = EN_OFF;
    seg_d  = SEG_OFF;
    tick_d = frame_end;
    if (phase == PhDrive) begin
      en_d = digit_en(dig_q);
      if (s_pass_q) begin
        seg_d = banner_code(dig_q);
      end else if (s_err_q) begin
        seg_d = hex_seg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      dig_q     <= 2'd0;
      s_pass_q  <= 1'b0;
      s_err_q   <= 1'b0;
      s_value_q <= 16'h0000;
      en_q      <= EN_OFF;
      seg_q     <= SEG_OFF;
      tick_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dig_q  <= dig_d;
      en_q   <= en_d;
      seg_q  <= seg_d;
      tick_q <= tick_d;
      if (frame_end) begin
        s_pass_q  <= pass;
        s_err_q   <= err;
        s_value_q <= value;
      end
    end
  end

  assign segan_en   = en_q;
  assign segans     = seg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: table of input/expected-glyph records plus hand-written
// coherence, mid-slot reset and no-blank sequences.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset, pass, err;
  logic [15:0] value;
  logic [3:0]  segan_en;
  logic [7:0]  segans;
  logic        frame_tick;

  logic        reset_nb, pass_nb;
  logic [3:0]  segan_en_nb;
  logic [7:0]  segans_nb;
  logic        frame_tick_nb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIV(8), .BLANK(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .pass       (pass),
    .err        (err),
    .value      (value),
    .segan_en   (segan_en),
    .segans     (segans),
    .frame_tick (frame_tick)
  );

  seg_scan_ctrl #(.DIV(4), .BLANK(0)) dut_nb (
    .clk        (clk),
    .reset      (reset_nb),
    .pass       (pass_nb),
    .err        (1'b0),
    .value      (16'h0000),
    .segan_en   (segan_en_nb),
    .segans     (segans_nb),
    .frame_tick (frame_tick_nb)
  );

  typedef struct {
    logic        pass;
    logic        err;
    logic [15:0] value;
    logic [31:0] codes;  // {dig0, dig1, dig2, dig3}
  } vec_t;

  logic [3:0] en_tab [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Eight output cycles of one DIV=8/BLANK=2 slot for digit d.
  task automatic expect_slot(input string tag, input logic [7:0] code, input int d);
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("%s d%0d k%0d en", tag, d, k), {28'd0, segan_en},
            {28'd0, (k < 2) ? 4'hF : en_tab[d]});
      check($sformatf("%s d%0d k%0d seg", tag, d, k), {24'd0, segans},
            {24'd0, (k < 2) ? 8'hFF : code});
      check($sformatf("%s d%0d k%0d tick", tag, d, k), {31'd0, frame_tick},
            {31'd0, (d == 3 && k == 7)});
    end
  endtask

  task automatic expect_frame(input string tag, input logic [31:0] codes);
    for (int d = 0; d < 4; d++) begin
      expect_slot(tag, codes[31-8*d -: 8], d);
    end
  endtask

  task automatic do_reset(input string tag, input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("%s rst%0d en", tag, i), {28'd0, segan_en}, 32'h0000000F);
      check($sformatf("%s rst%0d seg", tag, i), {24'd0, segans}, 32'h000000FF);
      check($sformatf("%s rst%0d tick", tag, i), {31'd0, frame_tick}, 32'd0);
    end
    reset = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin
    en_tab[0] = 4'b0111;
    en_tab[1] = 4'b1011;
    en_tab[2] = 4'b1101;
    en_tab[3] = 4'b1110;

    vecs[0] = '{pass: 1'b1, err: 1'b0, value: 16'h0000, codes: 32'h92C1C6C6};
    vecs[1] = '{pass: 1'b0, err: 1'b1, value: 16'h1A2F, codes: 32'hF988A48E};
    vecs[2] = '{pass: 1'b1, err: 1'b1, value: 16'h1A2F, codes: 32'h92C1C6C6};
    vecs[3] = '{pass: 1'b0, err: 1'b0, value: 16'h1A2F, codes: 32'hFFFFFFFF};
    vecs[4] = '{pass: 1'b0, err: 1'b1, value: 16'h0123, codes: 32'hC0F9A4B0};
    vecs[5] = '{pass: 1'b0, err: 1'b1, value: 16'h4567, codes: 32'h999282F8};
    vecs[6] = '{pass: 1'b0, err: 1'b1, value: 16'h89AB, codes: 32'h80908883};
    vecs[7] = '{pass: 1'b0, err: 1'b1, value: 16'hCDEF, codes: 32'hC6A1868E};

    reset    = 1'b1;
    pass     = 1'b1;
    err      = 1'b0;
    value    = 16'h0000;
    reset_nb = 1'b1;
    pass_nb  = 1'b1;

    // Each record: reset, dark first frame, record's glyphs in the second.
    for (int v = 0; v < 8; v++) begin
      pass  = vecs[v].pass;
      err   = vecs[v].err;
      value = vecs[v].value;
      do_reset($sformatf("v%0d", v), 5);
      expect_frame($sformatf("v%0d f0", v), 32'hFFFFFFFF);
      expect_frame($sformatf("v%0d f1", v), vecs[v].codes);
    end

    // Coherence: value changes during slot 1; the frame keeps the old snapshot.
    pass  = 1'b0;
    err   = 1'b1;
    value = 16'h1A2F;
    do_reset("coh", 2);
    expect_frame("coh f0", 32'hFFFFFFFF);
    expect_slot("coh f1", 8'hF9, 0);
    value = 16'h0000;
    expect_slot("coh f1", 8'h88, 1);
    expect_slot("coh f1", 8'hA4, 2);
    expect_slot("coh f1", 8'h8E, 3);
    expect_frame("coh f2", 32'hC0C0C0C0);

    // Reset during dig 2 DRIVE: outputs blank next cycle and the scan restarts.
    pass = 1'b1;
    err  = 1'b0;
    do_reset("mid", 2);
    expect_frame("mid f0", 32'hFFFFFFFF);
    expect_slot("mid f1", 8'h92, 0);
    expect_slot("mid f1", 8'hC1, 1);
    for (int k = 0; k < 4; k++) begin
      step();
    end
    check("mid pre-reset en", {28'd0, segan_en}, {28'd0, 4'b1101});
    check("mid pre-reset seg", {24'd0, segans}, 32'h000000C6);
    do_reset("mid", 1);
    expect_frame("mid r f0", 32'hFFFFFFFF);
    expect_slot("mid r f1", 8'h92, 0);

    // BLANK=0, DIV=4: each enable held 4 cycles with no dark gap.
    repeat (2) step();
    reset_nb = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      check($sformatf("nb i%0d en", i), {28'd0, segan_en_nb}, {28'd0, en_tab[(i / 4) % 4]});
      check($sformatf("nb i%0d seg", i), {24'd0, segans_nb},
            {24'd0, (i < 16) ? 8'hFF : ((i / 4) % 4 == 0) ? 8'h92 :
                                       ((i / 4) % 4 == 1) ? 8'hC1 : 8'hC6});
      check($sformatf("nb i%0d tick", i), {31'd0, frame_tick_nb}, {31'd0, (i % 16 == 15)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
